radix4_mul_scheduler: RTL and testbench

RADIX4_MUL_SCHEDULER -- requirements
Module: radix4_mul_scheduler

---
 rtl/radix4_mul_scheduler_if.sv | 20 ++
 rtl/radix4_mul_scheduler.sv | 73 +++++++
 tb/tb_radix4_mul_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/radix4_mul_scheduler_if.sv
// radix4_mul_scheduler_if: requester-side and multiplier-side signals of the shared multiply scheduler
interface radix4_mul_scheduler_if;
  logic req0, req1;
  logic signed [7:0] x0, y0, x1, y1;
  logic [1:0] done;
  logic signed [15:0] result;
  logic timeout, busy;
  logic mul_reset, mul_start;
  logic signed [7:0] mul_x, mul_y;
  logic mul_ready;
  logic signed [15:0] mul_product;
  modport slave (
    input req0, req1, x0, y0, x1, y1, mul_ready, mul_product,
    output done, result, timeout, busy, mul_reset, mul_start, mul_x, mul_y
  );
  modport master (
    output req0, req1, x0, y0, x1, y1, mul_ready, mul_product,
    input done, result, timeout, busy, mul_reset, mul_start, mul_x, mul_y
  );
endinterface

// File: rtl/radix4_mul_scheduler.sv
// radix4_mul_scheduler: round-robin arbiter sharing one radix-4 multiplier between two requesters, with WAIT timeout
module radix4_mul_scheduler #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clock,
  input logic reset,
  radix4_mul_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic gid, last, clr, pick;
  logic signed [7:0] opx, opy;
  // on a tie the requester not served last wins; last resets to 1 so req0 takes the first tie
  assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
  assign bus.mul_reset = reset | clr;
  assign bus.mul_x = opx;
  assign bus.mul_y = opy;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      gid <= 1'b0;
      last <= 1'b1;
      clr <= 1'b0;
      opx <= '0;
      opy <= '0;
      bus.done <= 2'b00;
      bus.result <= '0;
      bus.timeout <= 1'b0;
      bus.busy <= 1'b0;
      bus.mul_start <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.req0 || bus.req1) begin
            gid <= pick;
            opx <= pick ? bus.x1 : bus.x0;
            opy <= pick ? bus.y1 : bus.y0;
            clr <= 1'b1;
            bus.busy <= 1'b1;
            state <= CLEAR;
          end
        CLEAR: begin
          clr <= 1'b0;
          bus.mul_start <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: begin
          bus.mul_start <= 1'b0;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT:
          // a ready seen on the final counted cycle still completes normally
          if (bus.mul_ready || cnt == CW'(TIMEOUT_CYCLES)) begin
            bus.result <= bus.mul_ready ? bus.mul_product : '0;
            bus.timeout <= ~bus.mul_ready;
            bus.done <= gid ? 2'b10 : 2'b01;
            state <= DONE;
          end else
            cnt <= cnt + CW'(1);
        DONE: begin
          bus.done <= 2'b00;
          bus.timeout <= 1'b0;
          bus.busy <= 1'b0;
          last <= gid;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_radix4_mul_scheduler.sv
// tb_radix4_mul_scheduler: directed and randomized checks of the scheduler against a timeline model
module tb_radix4_mul_scheduler;
  localparam int T = 64;
  logic clock = 1'b0;
  logic reset = 1'b1;
  radix4_mul_scheduler_if ifc();
  radix4_mul_scheduler #(.TIMEOUT_CYCLES(T)) dut (.clock(clock), .reset(reset), .bus(ifc.slave));
  always #5 clock = ~clock;
  int total = 0, bad = 0;
  int lat_mode = 1, cur_lat = 0, cd = 0;
  logic signed [7:0] px, py;
  // multiplier stand-in: ready cur_lat edges after start (0 = never), sticky until mul_reset
  always @(posedge clock)
    if (ifc.mul_reset) begin
      ifc.mul_ready <= 1'b0;
      ifc.mul_product <= '0;
      cd <= 0;
    end else if (ifc.mul_start) begin
      cd <= cur_lat;
      px <= ifc.mul_x;
      py <= ifc.mul_y;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        ifc.mul_ready <= 1'b1;
        ifc.mul_product <= px * py;
      end
    end
  function automatic int rand_lat();
    int k = int'($urandom % 16);
    return k == 0 ? 0 : k == 1 ? 63 + int'($urandom % 3) : 1 + int'($urandom % 12);
  endfunction
  // model: m_t counts cycles since grant; done lands at 4 + multiplier latency, capped by the timeout
  int m_t = 0, m_tdone = 0;
  logic m_id = 1'b0, m_last = 1'b1, m_abort = 1'b0, started = 1'b0;
  logic signed [7:0] m_x = 0, m_y = 0;
  logic signed [15:0] m_res = 0;
  always @(posedge clock)
    if (reset) begin
      started = 1'b1;
      m_t = 0;
      m_x = 0;
      m_y = 0;
      m_res = 0;
      m_last = 1'b1;
    end else if (m_t == 0) begin
      if (ifc.req0 || ifc.req1) begin
        if (ifc.req0 && ifc.req1) m_id = (m_last == 1'b1) ? 1'b0 : 1'b1;
        else m_id = ifc.req0 ? 1'b0 : 1'b1;
        m_x = m_id ? ifc.x1 : ifc.x0;
        m_y = m_id ? ifc.y1 : ifc.y0;
        cur_lat = lat_mode >= 0 ? lat_mode : rand_lat();
        m_abort = cur_lat == 0 || cur_lat > T;
        m_tdone = 4 + (m_abort ? T : cur_lat);
        m_t = 1;
      end
    end else if (m_t == m_tdone) begin
      m_last = m_id;
      m_t = 0;
    end else begin
      m_t++;
      if (m_t == m_tdone) m_res = m_abort ? 16'sd0 : m_x * m_y;
    end
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clock)
    if (started) begin
      chk("done", ifc.done, (m_t != 0 && m_t == m_tdone) ? (m_id ? 16'd2 : 16'd1) : 16'd0);
      chk("timeout", ifc.timeout, 16'(m_t != 0 && m_t == m_tdone && m_abort));
      chk("result", ifc.result, m_res);
      chk("busy", ifc.busy, 16'(m_t != 0));
      chk("mul_reset", ifc.mul_reset, 16'(reset || m_t == 1));
      chk("mul_start", ifc.mul_start, 16'(m_t == 2));
      chk("mul_x", ifc.mul_x, m_x);
      chk("mul_y", ifc.mul_y, m_y);
    end
  task automatic wait_done(output logic [1:0] d, output logic [15:0] r, output logic t, output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (ifc.done != 2'b00) break;
    end
    if (ifc.done == 2'b00) begin
      total++;
      bad++;
      $display("FAIL wait_done: got no done pulse expected one within 200 cycles");
    end
    d = ifc.done;
    r = ifc.result;
    t = ifc.timeout;
  endtask
  task automatic tick();
    @(negedge clock);
    #1;
  endtask
  task automatic new_ops(input int n, input logic r);
    if (n == 0) begin
      ifc.req0 = r;
      ifc.x0 = 8'($urandom);
      ifc.y0 = 8'($urandom);
    end else begin
      ifc.req1 = r;
      ifc.x1 = 8'($urandom);
      ifc.y1 = 8'($urandom);
    end
  endtask
  initial begin
    logic [1:0] d;
    logic [15:0] r;
    logic t;
    int n;
    ifc.req0 = 0; ifc.req1 = 0;
    ifc.x0 = 0; ifc.y0 = 0; ifc.x1 = 0; ifc.y1 = 0;
    repeat (3) @(negedge clock);
    chk("rst_done", ifc.done, 0);
    chk("rst_result", ifc.result, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_mul_reset", ifc.mul_reset, 1);
    chk("rst_mul_start", ifc.mul_start, 0);
    chk("rst_mul_x", ifc.mul_x, 0);
    #1 reset = 0;
    lat_mode = 3;
    ifc.x0 = 2; ifc.y0 = 4; ifc.x1 = -2; ifc.y1 = 7;
    ifc.req0 = 1; ifc.req1 = 1;
    wait_done(d, r, t, n);
    chk("tie_first_done", d, 2'b01);
    chk("tie_first_result", r, 16'd8);
    #1 ifc.req0 = 0;
    wait_done(d, r, t, n);
    chk("tie_second_done", d, 2'b10);
    chk("tie_second_result", r, 16'hFFF2);
    #1 lat_mode = 2;
    ifc.x0 = 3; ifc.y0 = 3; ifc.x1 = 4; ifc.y1 = 4;
    ifc.req0 = 1; ifc.req1 = 1;
    for (int i = 0; i < 4; i++) begin
      wait_done(d, r, t, n);
      chk($sformatf("hold_seq%0d", i), d, (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    #1 ifc.req0 = 0; ifc.req1 = 0;
    tick();
    lat_mode = 20; ifc.x0 = 3; ifc.y0 = 5; ifc.req0 = 1;
    wait_done(d, r, t, n);
    chk("basic_done", d, 2'b01);
    chk("basic_result", r, 16'd15);
    chk("basic_timeout", t, 0);
    chk("basic_latency", n, 24);
    #1 ifc.req0 = 0;
    tick();
    lat_mode = 0; ifc.x1 = 5; ifc.y1 = 5; ifc.req1 = 1;
    wait_done(d, r, t, n);
    chk("abort_done", d, 2'b10);
    chk("abort_timeout", t, 1);
    chk("abort_result", r, 0);
    chk("abort_latency", n, 68);
    #1 ifc.req1 = 0;
    lat_mode = 5; ifc.x0 = 6; ifc.y0 = 7; ifc.req0 = 1;
    wait_done(d, r, t, n);
    chk("after_abort_done", d, 2'b01);
    chk("after_abort_result", r, 16'd42);
    chk("after_abort_timeout", t, 0);
    #1 ifc.req0 = 0;
    tick();
    lat_mode = 30; ifc.x0 = -5; ifc.y0 = 9; ifc.req0 = 1;
    repeat (10) @(negedge clock);
    #1 reset = 1;
    repeat (2) begin
      @(negedge clock);
      chk("midrst_busy", ifc.busy, 0);
      chk("midrst_done", ifc.done, 0);
      chk("midrst_mul_reset", ifc.mul_reset, 1);
    end
    #1 reset = 0;
    wait_done(d, r, t, n);
    chk("rearb_done", d, 2'b01);
    chk("rearb_result", r, 16'hFFD3);
    chk("rearb_timeout", t, 0);
    #1 ifc.req0 = 0;
    tick();
    lat_mode = 15; ifc.x0 = 10; ifc.y0 = 11; ifc.req0 = 1;
    repeat (6) @(negedge clock);
    #1 ifc.x0 = 99; ifc.y0 = -1;
    @(negedge clock);
    chk("latched_mul_x", ifc.mul_x, 10);
    chk("latched_mul_y", ifc.mul_y, 11);
    wait_done(d, r, t, n);
    chk("latched_result", r, 16'd110);
    #1 ifc.req0 = 0;
    lat_mode = -1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      d = ifc.done;
      #1;
      if (reset) reset = 0;
      else if ($urandom % 300 == 0) reset = 1;
      for (int k = 0; k < 2; k++) begin
        logic rq;
        rq = (k == 0) ? ifc.req0 : ifc.req1;
        if (d[k]) new_ops(k, $urandom % 4 != 0);
        else if (!rq && $urandom % 4 == 0) new_ops(k, 1'b1);
        else if (rq && m_t > 2 && int'(m_id) == k && $urandom % 6 == 0) new_ops(k, 1'b1);
      end
    end
    ifc.req0 = 0; ifc.req1 = 0;
    reset = 0;
    repeat (80) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
